card_dealer: RTL and testbench

//  Shares the shuffled deck between NUM_PLAYERS requesters. It sequences the deck controller's
//  get_card/card_ready handshake and serves players round-robin, with a per-player hand limit.

---
 rtl/card_dealer_pkg.sv | 26 ++
 rtl/card_dealer_rr_arbiter.sv | 31 +++
 rtl/card_dealer.sv | 171 +++++++++++++++++
 tb/tb_card_dealer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the card dealer and its round-robin arbiter.
package card_dealer_pkg;

  // Dealer controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_REQ     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5,
    ST_EMPTY   = 3'd6,
    ST_FAULT   = 3'd7
  } dealer_state_t;

  localparam int CARD_W_DEF    = 8;
  localparam int DECK_SIZE_DEF = 52;
  localparam int DEALT_W       = 6;   // cards_dealt width, so DECK_SIZE <= 63
  localparam int TMO_W         = 8;   // handshake timeout counter width

  // Width of a player index; at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/card_dealer_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible player at or
// after ptr, wrapping modulo N.
module rr_arbiter
  import card_dealer_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Scan N positions starting from ptr; the first hit wins.
  always_comb begin
    int j;
    j           = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_valid && eligible[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: arbitrates players round-robin, runs the get_card/card_ready
// handshake with the deck controller and tracks hand and deck counts.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int CARD_W      = CARD_W_DEF,
  parameter int DECK_SIZE   = DECK_SIZE_DEF,
  parameter int MAX_HAND    = 11,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   game_ready,
  input  logic                   card_ready,
  input  logic [CARD_W-1:0]      card_data,
  output logic                   get_card,
  input  logic [NUM_PLAYERS-1:0] req,
  input  logic                   new_round,
  output logic [NUM_PLAYERS-1:0] ack,
  output logic [CARD_W-1:0]      card_out,
  output logic [NUM_PLAYERS-1:0] hand_full,
  output logic [DEALT_W-1:0]     cards_dealt,
  output logic                   deck_empty,
  output logic                   busy,
  output logic                   fault
);

  localparam int                 IDX_W     = idx_w(NUM_PLAYERS);
  localparam int                 HAND_W    = $clog2(MAX_HAND + 1);
  localparam logic [HAND_W-1:0]  HAND_MAX  = HAND_W'(MAX_HAND);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [DEALT_W-1:0] DECK_FULL = DEALT_W'(DECK_SIZE);

  dealer_state_t           state_q, state_nx;
  logic [IDX_W-1:0]        grant_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [TMO_W-1:0]        tmo_q;
  logic [HAND_W-1:0]       hand_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  eligible;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_vld;

  // Hand count increment that holds at MAX_HAND.
  function automatic logic [HAND_W-1:0] sat_inc(input logic [HAND_W-1:0] v);
    return (v == HAND_MAX) ? v : v + HAND_W'(1);
  endfunction

  // Player index after g, wrapping modulo NUM_PLAYERS.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_PLAYERS - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  // Per-player full flags and the eligibility mask fed to the arbiter.
  always_comb begin
    hand_full = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hand_full[i] = (hand_q[i] == HAND_MAX);
    end
    eligible = req & ~hand_full;
  end

  rr_arbiter #(
    .N     (NUM_PLAYERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_vld)
  );

  // Next-state and decoded outputs.
  always_comb begin
    state_nx   = state_q;
    get_card   = 1'b0;
    busy       = 1'b0;
    fault      = 1'b0;
    ack        = '0;
    deck_empty = (cards_dealt == DECK_FULL);
    case (state_q)
      ST_IDLE: begin
        if (game_ready) state_nx = ST_ARB;
      end
      ST_ARB: begin
        if (arb_vld) state_nx = ST_REQ;
      end
      ST_REQ: begin
        get_card = 1'b1;
        busy     = 1'b1;
        if (card_ready)             state_nx = ST_CAPTURE;
        else if (tmo_q == TMO_LAST) state_nx = ST_FAULT;
      end
      ST_CAPTURE: begin
        get_card     = 1'b1;
        busy         = 1'b1;
        ack[grant_q] = 1'b1;
        state_nx     = ST_RELEASE;
      end
      ST_RELEASE: begin
        busy = 1'b1;
        if (!card_ready)            state_nx = ST_DONE;
        else if (tmo_q == TMO_LAST) state_nx = ST_FAULT;
      end
      ST_DONE: begin
        busy     = 1'b1;
        state_nx = (cards_dealt == DECK_FULL) ? ST_EMPTY : ST_ARB;
      end
      ST_EMPTY: begin
        state_nx = ST_EMPTY;
      end
      ST_FAULT: begin
        fault    = 1'b1;
        state_nx = ST_FAULT;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register; reset drops get_card immediately via the state decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nx;
  end

  // Handshake timeout counter, restarted on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     tmo_q <= '0;
    else if (state_nx != state_q)  tmo_q <= '0;
    else if (tmo_q != '1)          tmo_q <= tmo_q + TMO_W'(1);
  end

  // Grant latch in ARB; round-robin pointer advances past the served player.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (state_q == ST_ARB && arb_vld) grant_q <= arb_idx;
      if (state_q == ST_CAPTURE)        ptr_q   <= next_idx(grant_q);
    end
  end

  // Card is taken on the edge that sees card_ready, so card_out is already
  // valid during the ack cycle and holds until the next deal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                card_out <= '0;
    else if (state_q == ST_REQ && card_ready) card_out <= card_data;
  end

  // Deck count; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      cards_dealt <= '0;
    else if (state_q == ST_CAPTURE) cards_dealt <= cards_dealt + DEALT_W'(1);
  end

  // Hand counters; new_round takes priority over a coincident deal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) hand_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (new_round)
          hand_q[i] <= '0;
        else if (state_q == ST_CAPTURE && grant_q == IDX_W'(i))
          hand_q[i] <= sat_inc(hand_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer with a behavioural deck controller.
module tb_card_dealer;

  localparam int NP = 4;
  localparam int TO = 255;

  logic       clock = 1'b0;
  logic       reset;
  logic       game_ready;
  logic       card_ready = 1'b0;
  logic [7:0] card_data  = 8'h00;
  logic       get_card;
  logic [3:0] req;
  logic       new_round;
  logic [3:0] ack;
  logic [7:0] card_out;
  logic [3:0] hand_full;
  logic [5:0] cards_dealt;
  logic       deck_empty;
  logic       busy;
  logic       fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] card;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic [7:0] card;
    logic [5:0] dealt;
  } vec_t;
  vec_t tbl[10];

  int ack_count     = 0;
  bit get_card_seen = 1'b0;
  bit model_on      = 1'b1;
  int deal_idx      = 0;
  int wcnt          = 0;

  card_dealer #(
    .NUM_PLAYERS (NP),
    .CARD_W      (8),
    .DECK_SIZE   (52),
    .MAX_HAND    (11),
    .TIMEOUT     (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .game_ready  (game_ready),
    .card_ready  (card_ready),
    .card_data   (card_data),
    .get_card    (get_card),
    .req         (req),
    .new_round   (new_round),
    .ack         (ack),
    .card_out    (card_out),
    .hand_full   (hand_full),
    .cards_dealt (cards_dealt),
    .deck_empty  (deck_empty),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Deck controller model: card_ready two cycles after get_card, dropped after get_card falls.
  always @(negedge clock) begin
    if (reset) begin
      card_ready = 1'b0;
      card_data  = 8'h00;
      deal_idx   = 0;
      wcnt       = 0;
    end else if (model_on) begin
      if (get_card && !card_ready) begin
        wcnt++;
        if (wcnt == 2) begin
          card_ready = 1'b1;
          card_data  = 8'(16 + deal_idx);
          deal_idx++;
          wcnt = 0;
        end
      end else if (!get_card && card_ready) begin
        card_ready = 1'b0;
      end else if (!get_card) begin
        wcnt = 0;
      end
    end
  end

  // Output monitor: scoreboard compare on every ack.
  always @(posedge clock) begin : mon
    exp_t e;
    #1;
    if (get_card) get_card_seen = 1'b1;
    if (ack !== 4'b0000 && !reset) begin
      ack_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("ack", 32'(ack), 32'(e.ack));
        check("card_out", 32'(card_out), 32'(e.card));
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req       = 4'b0000;
    new_round = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_deal(input logic [3:0] r, input logic [3:0] ea, input logic [7:0] ec,
                         input bit nr_at_capture);
    int   start;
    bit   got;
    exp_t e;
    e.ack  = ea;
    e.card = ec;
    sb_q.push_back(e);
    start = ack_count;
    got   = 1'b0;
    req   = r;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clock);
      if (ack_count > start) got = 1'b1;
    end
    if (!got) begin
      check("deal_timeout", 32'(got), 32'h1);
      sb_q.delete();
    end else if (nr_at_capture) begin
      new_round = 1'b1;
    end
    req = 4'b0000;
    @(negedge clock);
    new_round = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    bit seen;
    tbl[0] = '{1'b0, 4'b1111, 4'b0001, 8'h10, 6'd1};
    tbl[1] = '{1'b0, 4'b1111, 4'b0010, 8'h11, 6'd2};
    tbl[2] = '{1'b0, 4'b1111, 4'b0100, 8'h12, 6'd3};
    tbl[3] = '{1'b0, 4'b1111, 4'b1000, 8'h13, 6'd4};
    tbl[4] = '{1'b0, 4'b1111, 4'b0001, 8'h14, 6'd5};
    tbl[5] = '{1'b1, 4'b0100, 4'b0100, 8'h10, 6'd1};
    tbl[6] = '{1'b0, 4'b0100, 4'b0100, 8'h11, 6'd2};
    tbl[7] = '{1'b0, 4'b0100, 4'b0100, 8'h12, 6'd3};
    tbl[8] = '{1'b0, 4'b0011, 4'b0001, 8'h13, 6'd4};
    tbl[9] = '{1'b0, 4'b0011, 4'b0010, 8'h14, 6'd5};

    reset      = 1'b1;
    game_ready = 1'b0;
    req        = 4'b0000;
    new_round  = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_get_card", 32'(get_card), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_card_out", 32'(card_out), 32'h0);
    check("rst_hand_full", 32'(hand_full), 32'h0);
    check("rst_cards_dealt", 32'(cards_dealt), 32'h0);
    check("rst_deck_empty", 32'(deck_empty), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    reset      = 1'b0;
    game_ready = 1'b1;

    // Round-robin order and single-requester pointer behaviour.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      do_deal(tbl[i].req, tbl[i].ack, tbl[i].card, 1'b0);
      check($sformatf("dealt_row%0d", i), 32'(cards_dealt), 32'(tbl[i].dealt));
    end

    // Hand limit blocks a player until new_round.
    do_reset();
    for (int k = 0; k < 11; k++) do_deal(4'b0010, 4'b0010, 8'(16 + k), 1'b0);
    check("full_hand_full", 32'(hand_full), 32'h2);
    get_card_seen = 1'b0;
    req = 4'b0010;
    repeat (20) @(negedge clock);
    check("full_no_get_card", 32'(get_card_seen), 32'h0);
    new_round = 1'b1;
    @(negedge clock);
    new_round = 1'b0;
    check("newround_hand_full", 32'(hand_full), 32'h0);
    do_deal(4'b0010, 4'b0010, 8'h1B, 1'b0);

    // new_round in the CAPTURE cycle: the new card is not counted.
    do_reset();
    for (int k = 0; k < 10; k++) do_deal(4'b0010, 4'b0010, 8'(16 + k), 1'b0);
    do_deal(4'b0010, 4'b0010, 8'h1A, 1'b1);
    check("coinc_hand_full", 32'(hand_full), 32'h0);
    for (int k = 0; k < 10; k++) do_deal(4'b0010, 4'b0010, 8'(27 + k), 1'b0);
    check("coinc_ten_not_full", 32'(hand_full), 32'h0);
    do_deal(4'b0010, 4'b0010, 8'h25, 1'b0);
    check("coinc_eleven_full", 32'(hand_full), 32'h2);

    // Whole deck, then terminal EMPTY.
    do_reset();
    for (int i = 0; i < 52; i++) begin
      if (i == 40) begin
        new_round = 1'b1;
        @(negedge clock);
        new_round = 1'b0;
      end
      do_deal(4'(1 << (i % 4)), 4'(1 << (i % 4)), 8'(16 + i), 1'b0);
    end
    repeat (3) @(negedge clock);
    check("empty_deck_empty", 32'(deck_empty), 32'h1);
    check("empty_cards_dealt", 32'(cards_dealt), 32'd52);
    check("empty_busy", 32'(busy), 32'h0);
    get_card_seen = 1'b0;
    req = 4'b1111;
    repeat (20) @(negedge clock);
    check("empty_no_get_card", 32'(get_card_seen), 32'h0);
    check("empty_still_empty", 32'(deck_empty), 32'h1);
    req = 4'b0000;

    // Controller never answers: fault after TIMEOUT cycles in REQ.
    do_reset();
    model_on = 1'b0;
    req  = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (get_card) seen = 1'b1;
    end
    check("tmo_get_card_rise", 32'(seen), 32'h1);
    cnt = 0;
    while (!fault && cnt < 400) begin
      @(negedge clock);
      cnt++;
    end
    check("tmo_latency", 32'(cnt), 32'(TO));
    check("tmo_fault", 32'(fault), 32'h1);
    check("tmo_get_card_low", 32'(get_card), 32'h0);
    check("tmo_busy", 32'(busy), 32'h0);
    do_reset();
    model_on = 1'b1;
    check("tmo_reset_clears", 32'(fault), 32'h0);

    // Asynchronous reset in REQ drops get_card before the next clock edge.
    req  = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (get_card) seen = 1'b1;
    end
    check("async_get_card_rise", 32'(seen), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_get_card_drop", 32'(get_card), 32'h0);
    check("async_busy_drop", 32'(busy), 32'h0);
    req = 4'b0000;
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
